// File: rtl/cpu_trace_fifo.sv
// Trace capture FIFO for the multicycle cpu. It records one {pc, wb} entry each time the PC changes and drains them on a FWFT valid/ready port.
// Optional: define CPU_TRACE_TS_EN to store a free-running timestamp with each entry and expose it on rd_ts.
module cpu_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       cap_en,
  input  logic [DW-1:0]              pc_in,
  input  logic [DW-1:0]              wb_in,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_pc,
  output logic [DW-1:0]              rd_wb,
`ifdef CPU_TRACE_TS_EN
  output logic [TS_W-1:0]            rd_ts,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] pc_mem [DEPTH];
  logic [DW-1:0] wb_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [15:0]   ovf_q;
  logic [DW-1:0] pc_last;
  logic          pc_last_vld;
  logic          cap_event, pop, push, drop;

`ifdef CPU_TRACE_TS_EN
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [TS_W-1:0] ts_q;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign ovf_cnt  = ovf_q;
  assign rd_valid = !empty;

  assign cap_event = cap_en && (!pc_last_vld || (pc_in != pc_last));
  assign pop       = rd_valid && rd_ready;
  // A pop frees the slot the same cycle, so a full FIFO can still accept.
  assign push      = cap_event && (!full || pop);
  assign drop      = cap_event && full && !pop;

  assign rd_pc = empty ? '0 : pc_mem[rd_ptr];
  assign rd_wb = empty ? '0 : wb_mem[rd_ptr];
`ifdef CPU_TRACE_TS_EN
  assign rd_ts = empty ? '0 : ts_mem[rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pc_in;
      wb_mem[wr_ptr] <= wb_in;
`ifdef CPU_TRACE_TS_EN
      ts_mem[wr_ptr] <= ts_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      pc_last     <= '0;
      pc_last_vld <= 1'b0;
    end else begin
      if (cap_event) begin
        pc_last     <= pc_in;
        pc_last_vld <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (drop && (ovf_q != '1)) ovf_q <= ovf_q + 16'd1;
    end
  end

`ifdef CPU_TRACE_TS_EN
  always_ff @(posedge clk) begin
    if (!reset || clear) ts_q <= '0;
    else                 ts_q <= ts_q + TS_W'(1);
  end
`endif

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Self-checking bench for cpu_trace_fifo: a queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_cpu_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, clear, cap_en, rd_ready;
  logic [31:0] pc_in, wb_in;
  logic        rd_valid, full, empty;
  logic [31:0] rd_pc, rd_wb;
  logic [4:0]  count;
  logic [15:0] ovf_cnt;

  cpu_trace_fifo #(.DEPTH(DEPTH), .DW(32), .TS_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cap_en(cap_en),
    .pc_in(pc_in), .wb_in(wb_in), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_wb(rd_wb),
    .count(count), .full(full), .empty(empty), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] wb; } ent_t;
  ent_t        q[$];
  logic [31:0] m_last;
  logic        m_vld;
  int unsigned m_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic r, input logic c, input logic ce,
                      input logic [31:0] p, input logic [31:0] w, input logic rr);
    bit ev;
    reset = r; clear = c; cap_en = ce; pc_in = p; wb_in = w; rd_ready = rr;
    @(posedge clk);
    if (!r || c) begin
      q.delete(); m_vld = 0; m_last = '0; m_ovf = 0;
    end else begin
      ev = ce && (!m_vld || p != m_last);
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (ev) begin
        m_last = p; m_vld = 1;
        if (q.size() < DEPTH) q.push_back('{pc: p, wb: w});
        else if (m_ovf < 16'hFFFF) m_ovf++;
      end
    end
    @(negedge clk);
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("rd_pc",    64'(rd_pc),    (q.size() != 0) ? 64'(q[0].pc) : 64'd0);
    chk("rd_wb",    64'(rd_wb),    (q.size() != 0) ? 64'(q[0].wb) : 64'd0);
    chk("count",    64'(count),    64'(q.size()));
    chk("full",     64'(full),     64'(q.size() == DEPTH));
    chk("empty",    64'(empty),    64'(q.size() == 0));
    chk("ovf_cnt",  64'(ovf_cnt),  64'(m_ovf));
  endtask

  int prob_tab[8] = '{10, 50, 90, 0, 100, 30, 70, 5};

  initial begin
    reset = 1'b0; clear = 1'b0; cap_en = 1'b0; pc_in = '0; wb_in = '0; rd_ready = 1'b0;
    m_vld = 0; m_last = '0; m_ovf = 0;

    // 1: reset held
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h55, 32'h66, 1);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_full", 64'(full), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_ovf", 64'(ovf_cnt), 64'd0);

    // 2: three captures then in-order drain
    step(1, 0, 1, 32'h0, 32'h11, 0);
    step(1, 0, 1, 32'h4, 32'h22, 0);
    step(1, 0, 1, 32'h8, 32'h33, 0);
    chk("t2_count", 64'(count), 64'd3);
    chk("t2_h0", {rd_pc, rd_wb}, {32'h0, 32'h11});
    step(1, 0, 0, 32'h8, 32'h0, 1);
    chk("t2_h1", {rd_pc, rd_wb}, {32'h4, 32'h22});
    step(1, 0, 0, 32'h8, 32'h0, 1);
    chk("t2_h2", {rd_pc, rd_wb}, {32'h8, 32'h33});
    step(1, 0, 0, 32'h8, 32'h0, 1);
    chk("t2_empty", 64'(empty), 64'd1);

    // 3: held PC yields one entry with first wb
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'h100, 32'hA0 + 32'(i), 0);
    chk("t3_count", 64'(count), 64'd1);
    chk("t3_entry", {rd_pc, rd_wb}, {32'h100, 32'hA0});

    // 4: overflow after 18 distinct PCs
    step(1, 1, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 18; i++) step(1, 0, 1, 32'h1000 + 32'(4 * i), 32'(i), 0);
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_ovf", 64'(ovf_cnt), 64'd2);
    chk("t4_head", 64'(rd_pc), 64'h1000);

    // 5: full with simultaneous push and pop
    step(1, 0, 1, 32'h2000, 32'h77, 1);
    chk("t5_count", 64'(count), 64'd16);
    chk("t5_ovf", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 15; i++) begin
      chk("t5_order", 64'(rd_pc), 64'h1004 + 64'(4 * i));
      step(1, 0, 0, 32'h2000, 32'h0, 1);
    end
    chk("t5_last", {rd_pc, rd_wb}, {32'h2000, 32'h77});
    step(1, 0, 0, 32'h2000, 32'h0, 1);

    // 6: clear discards the pending event and forgets pc history
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'h3000 + 32'(4 * i), 32'(i), 0);
    chk("t6_pre", 64'(count), 64'd5);
    step(1, 1, 1, 32'h4000, 32'h9, 0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_ovf", 64'(ovf_cnt), 64'd0);
    step(1, 0, 1, 32'h3010, 32'h5A, 1);
    chk("t6_recap", {27'd0, count, rd_pc}, {27'd0, 5'd1, 32'h3010});

    // Randomized traffic with varying drain pressure, occasional clear and reset
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) != 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) != 0, 32'($urandom_range(0, 11)) << 2, $urandom,
           $urandom_range(0, 99) < prob_tab[(i / 500) % 8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
